// File: rtl/rans_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : rans_encoder_param
// Description : Streaming rANS encoder with multi-word renormalisation and an
//               iterative restoring divider. Optional flush via ANS_ENC_FLUSH_EN.
// Revision    : 1.0  initial release
// ============================================================================
module rans_encoder_param #(
    parameter int STATE_W   = 32,
    parameter int OUT_W     = 8,
    parameter int PROB_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [PROB_BITS:0]   in_freq,
    input  logic [PROB_BITS-1:0] in_cum,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 busy,
    output logic                 err
`ifdef ANS_ENC_FLUSH_EN
    ,
    input  logic                 flush_req,
    output logic                 flush_done
`endif
);

    localparam int                  c_CNT_W    = $clog2(STATE_W);
    localparam logic [c_CNT_W-1:0]  c_DIV_LAST = c_CNT_W'(STATE_W - 1);
    localparam logic [STATE_W-1:0]  c_L        = STATE_W'(1) << (STATE_W - OUT_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RENORM = 3'd1,
        S_DIVIDE = 3'd2,
        S_UPDATE = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STATE_W-1:0]     r_x;
    logic [PROB_BITS:0]     r_freq;
    logic [PROB_BITS-1:0]   r_cum;
    logic [STATE_W-1:0]     r_quo;
    logic [PROB_BITS:0]     r_rem;
    logic [c_CNT_W-1:0]     r_div_cnt;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_out_vld;
    logic                   r_err;

    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_flush_go;
    logic [STATE_W:0]       w_x_max;
    logic                   w_need_word;
    logic [PROB_BITS+1:0]   w_trial;
    logic [PROB_BITS:0]     w_diff;
    logic                   w_qbit;
    logic [PROB_BITS:0]     w_rem_nxt;
    logic [STATE_W-1:0]     w_x_upd;

`ifdef ANS_ENC_FLUSH_EN
    localparam int                  c_FLUSH_WORDS = STATE_W / OUT_W;
    localparam int                  c_FCNT_W      = $clog2(c_FLUSH_WORDS + 1);
    localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST  = c_FCNT_W'(c_FLUSH_WORDS - 1);

    logic [c_FCNT_W-1:0]    r_flush_cnt;
    logic                   r_flush_done;

    // A flush request pre-empts any symbol offered in the same cycle.
    assign w_flush_go = flush_req && (r_state == S_IDLE) && ena;
    assign in_rdy     = (r_state == S_IDLE) && !flush_req;
    assign flush_done = r_flush_done;
`else
    assign w_flush_go = 1'b0;
    assign in_rdy     = (r_state == S_IDLE);
`endif

    assign w_in_xfer  = in_vld && in_rdy && ena;
    assign w_out_xfer = r_out_vld && out_rdy && ena;

    // Evaluated one bit wider than the state so freq = 2^PROB_BITS cannot wrap.
    assign w_x_max     = {r_freq, {(STATE_W - PROB_BITS){1'b0}}};
    assign w_need_word = ({1'b0, r_x} >= w_x_max);

    // Restoring divide: the dividend shifts out of r_quo while quotient bits shift in.
    assign w_trial   = {r_rem, r_quo[STATE_W-1]};
    assign w_qbit    = (w_trial >= {1'b0, r_freq});
    assign w_diff    = w_trial[PROB_BITS:0] - r_freq;
    assign w_rem_nxt = w_qbit ? w_diff : w_trial[PROB_BITS:0];

    assign w_x_upd = (r_quo << PROB_BITS) + STATE_W'(r_rem) + STATE_W'(r_cum);

    assign out_data = r_out_data;
    assign out_vld  = r_out_vld;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_flush_go) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_in_xfer && (in_freq != '0)) begin
                    w_state_nxt = S_RENORM;
                end
            end
            S_RENORM: begin
                if (!r_out_vld && !w_need_word) begin
                    w_state_nxt = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: w_state_nxt = S_IDLE;
`ifdef ANS_ENC_FLUSH_EN
            S_FLUSH: begin
                if (w_out_xfer && (r_flush_cnt == c_FLUSH_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x        <= c_L;
            r_freq     <= '0;
            r_cum      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_div_cnt  <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_err      <= 1'b0;
`ifdef ANS_ENC_FLUSH_EN
            r_flush_cnt  <= '0;
            r_flush_done <= 1'b0;
`endif
        end else if (ena) begin
`ifdef ANS_ENC_FLUSH_EN
            r_flush_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_flush_go) begin
`ifdef ANS_ENC_FLUSH_EN
                        r_flush_cnt <= '0;
`endif
                    end else if (w_in_xfer) begin
                        r_freq <= in_freq;
                        r_cum  <= in_cum;
                        if (in_freq == '0) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RENORM: begin
                    if (r_out_vld) begin
                        if (out_rdy) begin
                            r_x       <= r_x >> OUT_W;
                            r_out_vld <= 1'b0;
                        end
                    end else if (w_need_word) begin
                        r_out_vld  <= 1'b1;
                        r_out_data <= r_x[OUT_W-1:0];
                    end else begin
                        r_quo     <= r_x;
                        r_rem     <= '0;
                        r_div_cnt <= '0;
                    end
                end
                S_DIVIDE: begin
                    r_quo     <= {r_quo[STATE_W-2:0], w_qbit};
                    r_rem     <= w_rem_nxt;
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
                S_UPDATE: begin
                    r_x <= w_x_upd;
                end
`ifdef ANS_ENC_FLUSH_EN
                S_FLUSH: begin
                    if (r_out_vld) begin
                        if (out_rdy) begin
                            r_out_vld <= 1'b0;
                            if (r_flush_cnt == c_FLUSH_LAST) begin
                                r_x          <= c_L;
                                r_flush_done <= 1'b1;
                            end else begin
                                r_x         <= r_x >> OUT_W;
                                r_flush_cnt <= r_flush_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_out_vld  <= 1'b1;
                        r_out_data <= r_x[OUT_W-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rans_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_rans_encoder_param
// Description : Directed, table-driven bench for rans_encoder_param.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rans_encoder_param;

    localparam int STATE_W   = 32;
    localparam int OUT_W     = 8;
    localparam int PROB_BITS = 12;
    localparam logic [31:0] L = 32'h0100_0000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena = 1'b1;
    logic [PROB_BITS:0]   in_freq = '0;
    logic [PROB_BITS-1:0] in_cum = '0;
    logic                 in_vld = 1'b0;
    logic                 in_rdy;
    logic [OUT_W-1:0]     out_data;
    logic                 out_vld;
    logic                 out_rdy = 1'b1;
    logic                 busy;
    logic                 err;
`ifdef ANS_ENC_FLUSH_EN
    logic                 flush_req = 1'b0;
    logic                 flush_done;
`endif

    rans_encoder_param #(
        .STATE_W  (STATE_W),
        .OUT_W    (OUT_W),
        .PROB_BITS(PROB_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_freq   (in_freq),
        .in_cum    (in_cum),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .err       (err)
`ifdef ANS_ENC_FLUSH_EN
        ,
        .flush_req (flush_req),
        .flush_done(flush_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PROB_BITS:0]   f;
        logic [PROB_BITS-1:0] c;
        int                   n;
        logic [7:0]           w0;
        logic [7:0]           w1;
        logic [31:0]          x;
        logic                 e;
    } vec_t;

    vec_t       vecs[9];
    int         n_vec = 0;
    int         n_err = 0;
    int         got_n;
    int         got_lat;
    logic [7:0] got_w[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until the encoder is idle again, recording every transferred word.
    task automatic wait_idle();
        while (!(in_rdy && !busy) && got_lat < 300) begin
            if (out_vld && out_rdy) begin
                if (got_n < 8) got_w[got_n] = out_data;
                got_n++;
            end
            tick();
            got_lat++;
        end
        if (got_lat >= 300) begin
            n_err++;
            $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
        end
    endtask

    task automatic send(input logic [PROB_BITS:0] f, input logic [PROB_BITS-1:0] c);
        int guard = 0;
        in_freq = f;
        in_cum  = c;
        in_vld  = 1'b1;
        while (!in_rdy && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            n_err++;
            $display("FAIL accept_timeout: got in_rdy=0 expected 1");
        end
        tick();
        in_vld  = 1'b0;
        got_n   = 0;
        got_lat = 1;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{13'd4096, 12'd0,    0, 8'h00, 8'h00, 32'h0100_0000, 1'b0};
        vecs[1] = '{13'd4096, 12'd100,  0, 8'h00, 8'h00, 32'h0100_0064, 1'b0};
        vecs[2] = '{13'd2048, 12'd5,    0, 8'h00, 8'h00, 32'h0200_0069, 1'b0};
        vecs[3] = '{13'd1,    12'd7,    1, 8'h69, 8'h00, 32'h2000_0007, 1'b0};
        vecs[4] = '{13'd1,    12'd0,    2, 8'h07, 8'h00, 32'h0200_0000, 1'b0};
        vecs[5] = '{13'd3,    12'd10,   1, 8'h00, 8'h00, 32'h0AAA_A00C, 1'b0};
        vecs[6] = '{13'd100,  12'd4000, 1, 8'h0C, 8'h00, 32'h01B4_EFC8, 1'b0};
        vecs[7] = '{13'd0,    12'd0,    0, 8'h00, 8'h00, 32'h01B4_EFC8, 1'b1};
        vecs[8] = '{13'd4095, 12'd1,    0, 8'h00, 8'h00, 32'h01B5_0B19, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_x",       dut.r_x,  L);
        check("rst_in_rdy",  32'(in_rdy),  32'd1);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_data",    32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].f, vecs[i].c);
            check($sformatf("v%0d_nwords", i), 32'(got_n), 32'(vecs[i].n));
            if (vecs[i].n >= 1 && got_n >= 1) check($sformatf("v%0d_w0", i), 32'(got_w[0]), 32'(vecs[i].w0));
            if (vecs[i].n >= 2 && got_n >= 2) check($sformatf("v%0d_w1", i), 32'(got_w[1]), 32'(vecs[i].w1));
            check($sformatf("v%0d_x", i),   dut.r_x,   vecs[i].x);
            check($sformatf("v%0d_err", i), 32'(err),  32'(vecs[i].e));
            check($sformatf("v%0d_lat", i), 32'(got_lat),
                  (vecs[i].f == 0) ? 32'd1 : 32'(35 + 2 * vecs[i].n));
        end

        // Reset clears the sticky error and restores x.
        rst_n = 1'b0;
        tick();
        check("rst2_err",    32'(err),    32'd0);
        check("rst2_x",      dut.r_x,     L);
        check("rst2_in_rdy", 32'(in_rdy), 32'd1);
        check("rst2_busy",   32'(busy),   32'd0);
        rst_n = 1'b1;
        tick();

        // Output back-pressure, then enable freeze, then release.
        out_rdy = 1'b0;
        in_freq = 13'd1;
        in_cum  = 12'd0;
        in_vld  = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("stall_vld",  32'(out_vld),  32'd1);
            check("stall_data", 32'(out_data), 32'd0);
            check("stall_x",    dut.r_x,       L);
            tick();
        end
        ena     = 1'b0;
        out_rdy = 1'b1;
        repeat (3) begin
            tick();
            check("freeze_vld", 32'(out_vld), 32'd1);
            check("freeze_x",   dut.r_x,      L);
        end
        ena = 1'b1;
        tick();
        check("release_vld", 32'(out_vld), 32'd0);
        check("release_x",   dut.r_x,      32'h0001_0000);
        got_n   = 0;
        got_lat = 0;
        wait_idle();
        check("stall_final_x", dut.r_x,  32'h1000_0000);
        check("stall_nwords",  32'(got_n), 32'd0);

        // Reset in the middle of a divide.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_freq = 13'd4096;
        in_cum  = 12'd0;
        in_vld  = 1'b1;
        tick();
        in_vld = 1'b0;
        repeat (10) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy",    32'(busy),    32'd0);
        check("mid_rst_x",       dut.r_x,      L);
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_in_rdy",  32'(in_rdy),  32'd1);
        tick();

`ifdef ANS_ENC_FLUSH_EN
        begin
            int guard = 0;
            int pulses = 0;
            flush_req = 1'b1;
            check("flush_in_rdy", 32'(in_rdy), 32'd0);
            tick();
            flush_req = 1'b0;
            got_n = 0;
            while (pulses == 0 && guard < 100) begin
                if (out_vld && out_rdy) begin
                    if (got_n < 8) got_w[got_n] = out_data;
                    got_n++;
                end
                tick();
                guard++;
                if (flush_done) pulses++;
            end
            check("flush_done", 32'(pulses), 32'd1);
            check("flush_nwords", 32'(got_n), 32'd4);
            if (got_n >= 4) begin
                check("flush_w0", 32'(got_w[0]), 32'h00);
                check("flush_w1", 32'(got_w[1]), 32'h00);
                check("flush_w2", 32'(got_w[2]), 32'h00);
                check("flush_w3", 32'(got_w[3]), 32'h01);
            end
            check("flush_x", dut.r_x, L);
            tick();
            check("flush_pulse_end", 32'(flush_done), 32'd0);
            check("flush_idle", 32'(busy), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
